// File: rtl/fetch_inst_queue_pkg.sv
// Shared types and sizing for the fetch-to-decode instruction queue.
package fetch_inst_queue_pkg;

    localparam int FETCH_WIDTH  = 4;
    localparam int DECODE_WIDTH = 4;
    localparam int IQ_DEPTH     = 16;

    localparam int IQ_PTR_W     = $clog2(IQ_DEPTH);
    localparam int FETCH_OFF_W  = $clog2(FETCH_WIDTH);
    localparam int FETCH_CNT_W  = $clog2(FETCH_WIDTH + 1);

    typedef logic [IQ_PTR_W-1:0] iqPtr_t;
    typedef logic [IQ_PTR_W:0]   iqCnt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetchEntry_t;

    // True when the mask is a run of ones starting at bit 0 (including all-zero).
    function automatic bit is_thermo(input logic [DECODE_WIDTH-1:0] m);
        logic [DECODE_WIDTH-1:0] inc;
        inc = m + {{(DECODE_WIDTH-1){1'b0}}, 1'b1};
        return (inc & m) == '0;
    endfunction

endpackage

// File: rtl/fetch_inst_queue_lane_compactor.sv
// Turns a sparse lane valid mask into per-lane write offsets (exclusive
// prefix popcount) and the total number of valid lanes.
module lane_compactor #(
    parameter int W     = 4,
    parameter int OFF_W = $clog2(W),
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]            vld,
    output logic [W-1:0][OFF_W-1:0] offset,
    output logic [CNT_W-1:0]        total
);

    // Running count of valid lanes below each lane gives its slot offset.
    always_comb begin
        logic [CNT_W-1:0] acc;
        acc    = '0;
        offset = '0;
        for (int i = 0; i < W; i++) begin
            offset[i] = acc[OFF_W-1:0];
            acc       = acc + CNT_W'(vld[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/fetch_inst_queue.sv
// Decoupling queue between fetch and decode: compacts sparse fetch lanes
// into a circular buffer in program order and presents the oldest entries.
module fetch_inst_queue
    import fetch_inst_queue_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_squash_vld,
    input  logic [FETCH_WIDTH-1:0]        i_inst_vld,
    input  fetchEntry_t [FETCH_WIDTH-1:0] i_inst,
    output logic                          o_stall,
    input  logic                          i_backend_stall,
    output logic [DECODE_WIDTH-1:0]       o_inst_vld,
    output fetchEntry_t [DECODE_WIDTH-1:0] o_inst
);

    fetchEntry_t mem [IQ_DEPTH];

    iqPtr_t head_q;
    iqPtr_t tail_q;
    iqCnt_t count_q;

    logic [FETCH_WIDTH-1:0][FETCH_OFF_W-1:0] lane_off;
    logic [FETCH_CNT_W-1:0]                  lane_total;

    logic   enq_fire;
    logic   deq_fire;
    iqCnt_t enq_n;
    iqCnt_t deq_n;

    lane_compactor #(
        .W     (FETCH_WIDTH),
        .OFF_W (FETCH_OFF_W),
        .CNT_W (FETCH_CNT_W)
    ) u_compactor (
        .vld    (i_inst_vld),
        .offset (lane_off),
        .total  (lane_total)
    );

    // Stall from the registered count only, so the frontend sees no input path.
    // Using the pre-dequeue count is deliberately conservative.
    assign o_stall = (count_q > iqCnt_t'(IQ_DEPTH - FETCH_WIDTH));

    // Enqueue/dequeue qualification and the amounts moved this cycle.
    always_comb begin
        enq_fire = (|i_inst_vld) && !o_stall && !i_squash_vld;
        deq_fire = !i_backend_stall && !i_squash_vld;
        enq_n    = enq_fire ? iqCnt_t'(lane_total) : '0;
        if (!deq_fire)
            deq_n = '0;
        else if (count_q > iqCnt_t'(DECODE_WIDTH))
            deq_n = iqCnt_t'(DECODE_WIDTH);
        else
            deq_n = count_q;
    end

    // Pointer and occupancy update; squash and reset both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || i_squash_vld) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + iqPtr_t'(deq_n);
            tail_q  <= tail_q + iqPtr_t'(enq_n);
            count_q <= count_q + enq_n - deq_n;
        end
    end

    // Storage write: each valid lane lands at tail plus its compacted offset.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (i_inst_vld[i])
                    mem[tail_q + iqPtr_t'(lane_off[i])] <= i_inst[i];
            end
        end
    end

    // Output lanes read the oldest entries straight from storage; pointer math wraps.
    always_comb begin
        o_inst     = '0;
        o_inst_vld = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            o_inst[i]     = mem[head_q + iqPtr_t'(i)];
            o_inst_vld[i] = (iqCnt_t'(i) < count_q) && !i_squash_vld && !rst;
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= iqCnt_t'(IQ_DEPTH));

    a_no_enq_stalled: assert property (@(posedge clk) disable iff (rst)
        !(enq_fire && o_stall));

    a_vld_thermo: assert property (@(posedge clk) disable iff (rst)
        is_thermo(o_inst_vld));

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Randomized and directed checks of fetch_inst_queue against a queue-based model.
module tb_fetch_inst_queue;
    import fetch_inst_queue_pkg::*;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           i_squash_vld;
    logic [FETCH_WIDTH-1:0]         i_inst_vld;
    fetchEntry_t [FETCH_WIDTH-1:0]  i_inst;
    logic                           o_stall;
    logic                           i_backend_stall;
    logic [DECODE_WIDTH-1:0]        o_inst_vld;
    fetchEntry_t [DECODE_WIDTH-1:0] o_inst;

    int total = 0;
    int bad   = 0;

    fetchEntry_t mq[$];

    fetch_inst_queue dut (
        .clk             (clk),
        .rst             (rst),
        .i_squash_vld    (i_squash_vld),
        .i_inst_vld      (i_inst_vld),
        .i_inst          (i_inst),
        .o_stall         (o_stall),
        .i_backend_stall (i_backend_stall),
        .o_inst_vld      (o_inst_vld),
        .o_inst          (o_inst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit r, input bit sq, input logic [3:0] v, input int base, input bit bs);
        bit                      exp_stall;
        logic [DECODE_WIDTH-1:0] exp_vld;
        int                      n;
        @(negedge clk);
        rst             = r;
        i_squash_vld    = sq;
        i_inst_vld      = v;
        i_backend_stall = bs;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            i_inst[k].pc    = 32'(base + k);
            i_inst[k].instr = $urandom;
        end
        #1;
        exp_stall = (mq.size() > IQ_DEPTH - FETCH_WIDTH);
        for (int k = 0; k < DECODE_WIDTH; k++)
            exp_vld[k] = (k < mq.size()) && !sq && !r;
        chk("stall", 64'(o_stall), 64'(exp_stall));
        chk("vld", 64'(o_inst_vld), 64'(exp_vld));
        for (int k = 0; k < DECODE_WIDTH; k++)
            if (exp_vld[k]) chk($sformatf("lane%0d", k), 64'(o_inst[k]), 64'(mq[k]));
        if (r || sq) begin
            mq.delete();
        end else begin
            if (!bs) begin
                n = (mq.size() < DECODE_WIDTH) ? mq.size() : DECODE_WIDTH;
                repeat (n) void'(mq.pop_front());
            end
            if (v != 0 && !exp_stall)
                for (int k = 0; k < FETCH_WIDTH; k++)
                    if (v[k]) mq.push_back(i_inst[k]);
        end
    endtask

    initial begin
        rst = 1'b1; i_squash_vld = 1'b0; i_inst_vld = '0; i_backend_stall = 1'b0; i_inst = '0;

        // reset
        step(1, 0, 4'b0000, 0, 0);
        step(1, 0, 4'b0000, 0, 0);
        step(0, 0, 4'b0000, 0, 0);
        chk("rst_vld", 64'(o_inst_vld), 64'd0);
        chk("rst_stall", 64'(o_stall), 64'd0);

        // 1: full group, visible next cycle, gone the one after
        step(0, 0, 4'b1111, 0, 0);
        step(0, 0, 4'b0000, 0, 0);
        chk("t1_vld", 64'(o_inst_vld), 64'hF);
        for (int k = 0; k < 4; k++) chk("t1_id", 64'(o_inst[k].pc), 64'(k));
        step(0, 0, 4'b0000, 0, 0);
        chk("t1_empty", 64'(o_inst_vld), 64'd0);

        // 2: sparse lanes compacted (ids 0xA..0xD, lanes 1 and 3 valid)
        step(0, 0, 4'b1010, 32'hA, 0);
        step(0, 0, 4'b0000, 0, 1);
        chk("t2_vld", 64'(o_inst_vld), 64'h3);
        chk("t2_l0", 64'(o_inst[0].pc), 64'hB);
        chk("t2_l1", 64'(o_inst[1].pc), 64'hD);
        step(0, 0, 4'b0000, 0, 0);

        // 3: fill to 16 under backend stall, fifth group refused, drain in order
        for (int g = 0; g < 4; g++) step(0, 0, 4'b1111, 16 + 4*g, 1);
        step(0, 0, 4'b1111, 90, 1);
        chk("t3_stall", 64'(o_stall), 64'd1);
        for (int g = 0; g < 4; g++) begin
            step(0, 0, 4'b0000, 0, 0);
            chk("t3_vld", 64'(o_inst_vld), 64'hF);
            chk("t3_order", 64'(o_inst[0].pc), 64'(16 + 4*g));
            chk("t3_order3", 64'(o_inst[3].pc), 64'(19 + 4*g));
        end
        step(0, 0, 4'b0000, 0, 0);
        chk("t3_empty", 64'(o_inst_vld), 64'd0);

        // 4: wrap-around from slot 14
        step(1, 0, 4'b0000, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 0, 4'b0001, 50 + i, 0);
        step(0, 0, 4'b0000, 0, 0);
        step(0, 0, 4'b1111, 100, 1);
        step(0, 0, 4'b0000, 0, 1);
        chk("t4_vld", 64'(o_inst_vld), 64'hF);
        for (int k = 0; k < 4; k++) chk("t4_id", 64'(o_inst[k].pc), 64'(100 + k));
        step(0, 0, 4'b0000, 0, 0);

        // 5: squash at count 9 alongside an enqueue
        step(0, 0, 4'b1111, 120, 1);
        step(0, 0, 4'b1111, 124, 1);
        step(0, 0, 4'b0001, 128, 1);
        step(0, 1, 4'b1111, 130, 1);
        chk("t5_sq_vld", 64'(o_inst_vld), 64'd0);
        step(0, 0, 4'b0011, 200, 1);
        chk("t5_stall", 64'(o_stall), 64'd0);
        chk("t5_vld0", 64'(o_inst_vld), 64'd0);
        step(0, 0, 4'b0000, 0, 1);
        chk("t5_vld", 64'(o_inst_vld), 64'h3);
        chk("t5_l0", 64'(o_inst[0].pc), 64'd200);
        chk("t5_l1", 64'(o_inst[1].pc), 64'd201);
        step(0, 0, 4'b0000, 0, 0);

        // 6: full queue, dequeue and refused enqueue in the same cycle
        for (int g = 0; g < 4; g++) step(0, 0, 4'b1111, 400 + 4*g, 1);
        step(0, 0, 4'b1111, 300, 0);
        chk("t6_stall", 64'(o_stall), 64'd1);
        step(0, 0, 4'b0000, 0, 1);
        chk("t6_stall_after", 64'(o_stall), 64'd0);
        chk("t6_head", 64'(o_inst[0].pc), 64'd404);
        for (int i = 0; i < 4; i++) step(0, 0, 4'b0000, 0, 0);

        // random traffic with occasional squash and reset
        for (int c = 0; c < 3000; c++) begin
            bit r, sq, bs;
            r  = ($urandom_range(0, 249) == 0);
            sq = ($urandom_range(0, 59) == 0);
            if ((c / 300) % 2 == 1) bs = ($urandom_range(0, 9) < 8);
            else                    bs = ($urandom_range(0, 9) < 3);
            step(r, sq, 4'($urandom_range(0, 15)), 1000 + 4*c, bs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
